switch_allocator_wh: RTL

SWITCH_ALLOCATOR_WH -- requirements
Module: switch_allocator_wh

---
 rtl/switch_allocator_wh.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/switch_allocator_wh.sv
// Wormhole switch allocator: per-output round-robin arbitration among head flits,
// with each output held by its owner input until that owner's tail flit has transferred.
module switch_allocator_wh #(
  parameter int N = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N-1:0]     i_val,
  input  logic [N-1:0]     i_head,
  input  logic [N-1:0]     i_tail,
  input  logic [N*N-1:0]   i_output_req,
  input  logic [N-1:0]     i_out_ready,
  output logic [N*N-1:0]   o_out_sel,
  output logic [N-1:0]     o_out_val,
  output logic [N-1:0]     o_in_ack
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic         hit;
    r   = '0;
    hit = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (v[b] && !hit) begin
        r[b] = 1'b1;
        hit  = 1'b1;
      end else begin
        r[b] = r[b];
      end
    end
    return r;
  endfunction

  function automatic int rr_index(input logic [W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    else        s = s;
    return s;
  endfunction

  function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
    if (int'(p) == N - 1) return '0;
    else                  return p + W'(1);
  endfunction

  logic [N-1:0]         locked_q, locked_d;
  logic [N-1:0][W-1:0]  owner_q, owner_d;
  logic [N-1:0][W-1:0]  ptr_q, ptr_d;
  // Low until the first edge after reset release, so nothing moves in between.
  logic                 active_q, active_d;

  logic [N-1:0][N-1:0]  req_eff;   // indexed [input][output]
  logic [N-1:0][N-1:0]  grant;     // indexed [output][input]
  logic [N-1:0][W-1:0]  win;
  logic [N-1:0]         found;
  logic [N-1:0]         xfer;

  // Qualify each input's request: valid and only the lowest requested output.
  always_comb begin
    req_eff = '0;
    for (int i = 0; i < N; i++) begin
      if (i_val[i]) req_eff[i] = lowest_one(i_output_req[i*N +: N]);
      else          req_eff[i] = '0;
    end
  end

  // Per-output winner selection and transfer qualification.
  always_comb begin
    grant = '0;
    win   = '0;
    found = '0;
    xfer  = '0;
    for (int o = 0; o < N; o++) begin
      if (locked_q[o]) begin
        if (req_eff[owner_q[o]][o]) begin
          found[o] = 1'b1;
          win[o]   = owner_q[o];
        end else begin
          found[o] = 1'b0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!found[o] && req_eff[rr_index(ptr_q[o], k)][o] && i_head[rr_index(ptr_q[o], k)]) begin
            found[o] = 1'b1;
            win[o]   = W'(rr_index(ptr_q[o], k));
          end else begin
            found[o] = found[o];
          end
        end
      end
      xfer[o] = found[o] & i_out_ready[o] & active_q;
      if (xfer[o]) grant[o][win[o]] = 1'b1;
      else         grant[o] = '0;
    end
  end

  // Drive the crossbar selects, output valids and input acks from the grants.
  always_comb begin
    o_out_sel = '0;
    o_in_ack  = '0;
    o_out_val = xfer;
    for (int o = 0; o < N; o++) begin
      o_out_sel[o*N +: N] = grant[o];
      o_in_ack            = o_in_ack | grant[o];
    end
  end

  // Lock and pointer updates only happen on an actual transfer.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    active_d = 1'b1;
    for (int o = 0; o < N; o++) begin
      if (xfer[o]) begin
        if (locked_q[o]) begin
          locked_d[o] = ~i_tail[win[o]];
        end else begin
          locked_d[o] = ~i_tail[win[o]];
          owner_d[o]  = win[o];
          ptr_d[o]    = ptr_inc(win[o]);
        end
      end else begin
        locked_d[o] = locked_q[o];
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      locked_q <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      active_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
    end
  end

endmodule
